frame_scheduler: RTL and testbench
==================================

# frame_scheduler

Timing master of the sender map path. Generates the row/column slot counters for a 4-row x 1041-column frame. Pulls client payload bytes over a ready/valid handshake during payload columns only. Delivers slot-aligned counters and payload to the frame controller, which inserts FAS/overhead and emits line bytes one cycle later.

## Interface
- ROWS, 4, rows per frame (row counter width 2)
- COLS, 1041, columns per row, numbered 0..1040 (column counter width 11)
- OH_COLS, 16, overhead columns 0..15 per row; payload columns are 16..COLS-2 (1024 bytes/row)
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_enable  in  1  level; start/continue framing
- i_client_data  in  8  client payload byte
- i_client_valid  in  1  client byte available
- o_client_ready  out  1  scheduler accepts a byte this cycle
- o_row_cnt  out  2  row of the slot presented this cycle
- o_col_cnt  out  11  column of the slot presented this cycle
- o_pyld_data  out  8  payload byte for the presented slot
- o_pyld_data_valid  out  1  o_pyld_data holds a client byte
- o_frame_start  out  1  presented slot is row 0, col 0
- o_mframe_cnt  out  8  multiframe number of the presented slot
- o_underrun  out  1  presented payload slot was starved
- o_underrun_cnt  out  16  saturating count of starved payload slots

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: internal row/col = 0; o_client_ready = 0; output register holds o_* = 0. IDLE -> RUN when i_enable = 1; the first slot (0,0) is processed in the cycle after the enable is sampled.
- RUN: one slot per cycle, no stalls ever. Column increments; at col COLS-1 it wraps to 0 and row increments. At row ROWS-1, col COLS-1 it wraps to (0,0) and the internal multiframe counter increments mod 256.
- RUN -> DRAIN when i_enable = 0 is sampled. DRAIN continues slots identically through row ROWS-1, col COLS-1, then goes to IDLE. Only whole frames are emitted.
- DRAIN -> RUN if i_enable returns to 1 before the last slot; the frame continues without a gap.
- A payload slot is RUN or DRAIN with internal col in [OH_COLS, COLS-2].
- o_client_ready = 1 exactly in payload slots, combinational from state/col and independent of i_client_valid.
- Transfer = o_client_ready & i_client_valid.
- Payload slot with transfer: the byte is registered to o_pyld_data, o_pyld_data_valid = 1.
- Payload slot without transfer (underrun): o_pyld_data = 0x00, o_pyld_data_valid = 0, o_underrun = 1, o_underrun_cnt increments and saturates at 0xFFFF.
- Non-payload slot (cols 0..15 and 1040): o_pyld_data = 0x00, valid = 0, no underrun. Client data is ignored because ready = 0.
- o_frame_start = 1 for the presented slot (0,0), including the first slot after IDLE.

## Timing
- All o_* outputs except o_client_ready are registered. The counters, data, flags and multiframe number presented in cycle t+1 describe the slot processed (handshaked) in cycle t.
- Downstream frame controller adds 1 cycle, giving 2 cycles from client transfer to line output.
- Async reset: every output, the state, the counters and o_underrun_cnt go to 0 immediately, including mid-frame. o_client_ready drops in the same cycle. After reset release, operation resumes from IDLE.
- o_underrun_cnt clears only on reset.
- Frame period is 4164 cycles; payload is 4096 bytes/frame.

## Test plan
- Enable with client always valid (incrementing bytes) -> ready high at cols 16..1039 of every row. Bytes appear on o_pyld_data one cycle later in order. Presented cols go 0..1040 and wrap. o_frame_start pulses every 4164 cycles. o_mframe_cnt reaches 1 at the second frame.
- Client valid low for 3 payload slots at row 1 col 500 -> o_underrun high for presented cols 500..502 with data 0x00. o_underrun_cnt = 3. The frame does not stall.
- Client valid during cols 0..15 and 1040 -> ready = 0, no bytes consumed, the next payload byte is the same byte still pending.
- Drop i_enable at row 2 col 100 -> frame completes through presented (3,1040), then IDLE with all outputs 0. Re-enable in DRAIN at row 3 col 7 -> next frame follows with no gap.
- Assert i_rst at row 1 col 700 -> all outputs 0 and ready 0 asynchronously. After release and enable, the first presented slot is (0,0) with o_frame_start = 1 and o_mframe_cnt = 0.
- Force 65540 underruns -> o_underrun_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/frame_scheduler.sv
// frame_scheduler: 4x1041 slot timing master pulling client payload bytes over ready/valid
module frame_scheduler #(
  parameter int ROWS    = 4,
  parameter int COLS    = 1041,
  parameter int OH_COLS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [7:0]  i_client_data,
  input  logic        i_client_valid,
  output logic        o_client_ready,
  output logic [1:0]  o_row_cnt,
  output logic [10:0] o_col_cnt,
  output logic [7:0]  o_pyld_data,
  output logic        o_pyld_data_valid,
  output logic        o_frame_start,
  output logic [7:0]  o_mframe_cnt,
  output logic        o_underrun,
  output logic [15:0] o_underrun_cnt
);
  localparam logic [1:0]  ROW_LAST = 2'(ROWS - 1);
  localparam logic [10:0] COL_LAST = 11'(COLS - 1);
  localparam logic [10:0] PL_LO    = 11'(OH_COLS);
  localparam logic [10:0] PL_HI    = 11'(COLS - 2);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t      state;
  logic [1:0]  row;
  logic [10:0] col;
  logic [7:0]  mf;
  logic        payload;
  logic        xfer;
  logic        last;
  // slot classification of the slot being processed this cycle
  always_comb begin
    payload        = state != IDLE && col >= PL_LO && col <= PL_HI;
    xfer           = payload & i_client_valid;
    last           = row == ROW_LAST && col == COL_LAST;
    o_client_ready = payload;
  end
  // slot counters, framing FSM and registered presentation of the processed slot
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state             <= IDLE;
      row               <= '0;
      col               <= '0;
      mf                <= '0;
      o_row_cnt         <= '0;
      o_col_cnt         <= '0;
      o_pyld_data       <= '0;
      o_pyld_data_valid <= 1'b0;
      o_frame_start     <= 1'b0;
      o_mframe_cnt      <= '0;
      o_underrun        <= 1'b0;
      o_underrun_cnt    <= '0;
    end else if (state == IDLE) begin
      state             <= i_enable ? RUN : IDLE;
      row               <= '0;
      col               <= '0;
      o_row_cnt         <= '0;
      o_col_cnt         <= '0;
      o_pyld_data       <= '0;
      o_pyld_data_valid <= 1'b0;
      o_frame_start     <= 1'b0;
      o_mframe_cnt      <= '0;
      o_underrun        <= 1'b0;
    end else begin
      state             <= i_enable ? RUN : last ? IDLE : DRAIN;
      col               <= col == COL_LAST ? '0 : col + 11'd1;
      row               <= col != COL_LAST ? row : row == ROW_LAST ? '0 : row + 2'd1;
      mf                <= last ? mf + 8'd1 : mf;
      o_row_cnt         <= row;
      o_col_cnt         <= col;
      o_pyld_data       <= xfer ? i_client_data : 8'h00;
      o_pyld_data_valid <= xfer;
      o_frame_start     <= row == '0 && col == '0;
      o_mframe_cnt      <= mf;
      o_underrun        <= payload & ~i_client_valid;
      o_underrun_cnt    <= payload && !i_client_valid && o_underrun_cnt != 16'hFFFF ? o_underrun_cnt + 16'd1 : o_underrun_cnt;
    end
  end
endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: directed scenario bench for frame_scheduler
module tb_frame_scheduler;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic [7:0]  i_client_data;
  logic        i_client_valid;
  logic        o_client_ready;
  logic [1:0]  o_row_cnt;
  logic [10:0] o_col_cnt;
  logic [7:0]  o_pyld_data;
  logic        o_pyld_data_valid;
  logic        o_frame_start;
  logic [7:0]  o_mframe_cnt;
  logic        o_underrun;
  logic [15:0] o_underrun_cnt;
  logic [48:0] all_out;
  logic [32:0] flow_out;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_und = 0;
  logic [7:0]  nb;

  frame_scheduler dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
    .i_client_data(i_client_data), .i_client_valid(i_client_valid),
    .o_client_ready(o_client_ready), .o_row_cnt(o_row_cnt), .o_col_cnt(o_col_cnt),
    .o_pyld_data(o_pyld_data), .o_pyld_data_valid(o_pyld_data_valid),
    .o_frame_start(o_frame_start), .o_mframe_cnt(o_mframe_cnt),
    .o_underrun(o_underrun), .o_underrun_cnt(o_underrun_cnt)
  );

  always #5 i_clk = ~i_clk;

  assign all_out  = {o_client_ready, o_row_cnt, o_col_cnt, o_pyld_data, o_pyld_data_valid,
                     o_frame_start, o_mframe_cnt, o_underrun, o_underrun_cnt};
  assign flow_out = {o_client_ready, o_row_cnt, o_col_cnt, o_pyld_data, o_pyld_data_valid,
                     o_frame_start, o_mframe_cnt, o_underrun};

  // one clock: the client byte advances only when the handshake completed
  task automatic step();
    logic x;
    x = o_client_ready & i_client_valid;
    if (o_client_ready & !i_client_valid) exp_und++;
    @(posedge i_clk); #1;
    if (x) nb++;
    i_client_data = nb;
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_enable = 1'b0; i_client_valid = 1'b0; nb = 8'h00; i_client_data = 8'h00;
    repeat (2) @(posedge i_clk);
    #1;
    n_cmp++; if (all_out !== 49'd0) begin n_bad++; $display("FAIL reset_outputs got %h want 0", all_out); end
    i_rst = 1'b0;
    skip(2);
    n_cmp++; if (all_out !== 49'd0) begin n_bad++; $display("FAIL idle_outputs got %h want 0", all_out); end
  endtask

  task automatic test_stream();
    int r, c;
    logic pl;
    i_client_valid = 1'b1; i_enable = 1'b1;
    step();
    n_cmp++; if (all_out !== 49'd0) begin n_bad++; $display("FAIL stream_first_idle got %h want 0", all_out); end
    for (int idx = 0; idx < 4164; idx++) begin
      r = idx / 1041; c = idx % 1041; pl = c >= 16 && c <= 1039;
      n_cmp++; if (o_client_ready !== pl) begin n_bad++; $display("FAIL stream_ready r%0d c%0d got %b want %b", r, c, o_client_ready, pl); end
      step();
      n_cmp++; if ({o_row_cnt, o_col_cnt} !== {2'(r), 11'(c)}) begin n_bad++; $display("FAIL stream_slot got %0d,%0d want %0d,%0d", o_row_cnt, o_col_cnt, r, c); end
      n_cmp++; if ({o_frame_start, o_mframe_cnt, o_underrun} !== {idx == 0, 8'd0, 1'b0}) begin n_bad++; $display("FAIL stream_flags r%0d c%0d got fs%b mf%0d ur%b want fs%b mf0 ur0", r, c, o_frame_start, o_mframe_cnt, o_underrun, idx == 0); end
      n_cmp++; if ({o_pyld_data_valid, o_pyld_data} !== {pl, pl ? 8'(c - 16) : 8'h00}) begin n_bad++; $display("FAIL stream_data r%0d c%0d got v%b %h want v%b %h", r, c, o_pyld_data_valid, o_pyld_data, pl, pl ? 8'(c - 16) : 8'h00); end
    end
    step();
    n_cmp++; if ({o_row_cnt, o_col_cnt, o_frame_start, o_mframe_cnt} !== {2'd0, 11'd0, 1'b1, 8'd1}) begin n_bad++; $display("FAIL stream_second_frame got %0d,%0d fs%b mf%0d want 0,0 fs1 mf1", o_row_cnt, o_col_cnt, o_frame_start, o_mframe_cnt); end
  endtask

  task automatic test_underrun();
    logic [7:0] e;
    skip(1540);
    i_client_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if ({o_row_cnt, o_col_cnt, o_underrun, o_pyld_data_valid, o_pyld_data} !== {2'd1, 11'(500 + k), 1'b1, 1'b0, 8'h00}) begin n_bad++; $display("FAIL underrun_slot got %0d,%0d ur%b v%b %h want 1,%0d ur1 v0 00", o_row_cnt, o_col_cnt, o_underrun, o_pyld_data_valid, o_pyld_data, 500 + k); end
    end
    i_client_valid = 1'b1; e = nb;
    step();
    n_cmp++; if ({o_col_cnt, o_underrun, o_pyld_data_valid, o_pyld_data} !== {11'd503, 1'b0, 1'b1, e}) begin n_bad++; $display("FAIL underrun_recover got c%0d ur%b v%b %h want c503 ur0 v1 %h", o_col_cnt, o_underrun, o_pyld_data_valid, o_pyld_data, e); end
    n_cmp++; if (o_underrun_cnt !== 16'd3) begin n_bad++; $display("FAIL underrun_count got %0d want 3", o_underrun_cnt); end
  endtask

  task automatic test_overhead();
    logic [7:0] e;
    skip(536);
    e = nb;
    for (int k = 0; k < 17; k++) begin
      n_cmp++; if (o_client_ready !== 1'b0) begin n_bad++; $display("FAIL overhead_ready k%0d got %b want 0", k, o_client_ready); end
      step();
      n_cmp++; if ({o_pyld_data_valid, o_pyld_data, o_underrun} !== 10'd0) begin n_bad++; $display("FAIL overhead_data k%0d got v%b %h ur%b want v0 00 ur0", k, o_pyld_data_valid, o_pyld_data, o_underrun); end
    end
    n_cmp++; if (o_client_ready !== 1'b1) begin n_bad++; $display("FAIL overhead_ready_back got %b want 1", o_client_ready); end
    step();
    n_cmp++; if ({o_row_cnt, o_col_cnt, o_pyld_data_valid, o_pyld_data} !== {2'd2, 11'd16, 1'b1, e}) begin n_bad++; $display("FAIL overhead_pending got %0d,%0d v%b %h want 2,16 v1 %h", o_row_cnt, o_col_cnt, o_pyld_data_valid, o_pyld_data, e); end
    n_cmp++; if (o_underrun_cnt !== 16'd3) begin n_bad++; $display("FAIL overhead_count got %0d want 3", o_underrun_cnt); end
  endtask

  task automatic test_drain();
    skip(83);
    i_enable = 1'b0;
    step();
    skip(1980);
    n_cmp++; if ({o_row_cnt, o_col_cnt, o_pyld_data_valid} !== {2'd3, 11'd1039, 1'b1}) begin n_bad++; $display("FAIL drain_payload got %0d,%0d v%b want 3,1039 v1", o_row_cnt, o_col_cnt, o_pyld_data_valid); end
    step();
    n_cmp++; if ({o_row_cnt, o_col_cnt, o_pyld_data_valid} !== {2'd3, 11'd1040, 1'b0}) begin n_bad++; $display("FAIL drain_last got %0d,%0d v%b want 3,1040 v0", o_row_cnt, o_col_cnt, o_pyld_data_valid); end
    step();
    n_cmp++; if (flow_out !== 33'd0) begin n_bad++; $display("FAIL drain_idle got %h want 0", flow_out); end
    skip(3);
    n_cmp++; if (flow_out !== 33'd0) begin n_bad++; $display("FAIL drain_idle_hold got %h want 0", flow_out); end
    n_cmp++; if (o_underrun_cnt !== 16'd3) begin n_bad++; $display("FAIL drain_count got %0d want 3", o_underrun_cnt); end
  endtask

  task automatic test_reenable();
    i_enable = 1'b1;
    step();
    step();
    n_cmp++; if ({o_row_cnt, o_col_cnt, o_frame_start, o_mframe_cnt} !== {2'd0, 11'd0, 1'b1, 8'd2}) begin n_bad++; $display("FAIL reenable_start got %0d,%0d fs%b mf%0d want 0,0 fs1 mf2", o_row_cnt, o_col_cnt, o_frame_start, o_mframe_cnt); end
    skip(3129);
    i_enable = 1'b0;
    skip(11);
    i_enable = 1'b1;
    skip(1023);
    n_cmp++; if ({o_row_cnt, o_col_cnt} !== {2'd3, 11'd1040}) begin n_bad++; $display("FAIL reenable_last got %0d,%0d want 3,1040", o_row_cnt, o_col_cnt); end
    step();
    n_cmp++; if ({o_row_cnt, o_col_cnt, o_frame_start, o_mframe_cnt} !== {2'd0, 11'd0, 1'b1, 8'd3}) begin n_bad++; $display("FAIL reenable_no_gap got %0d,%0d fs%b mf%0d want 0,0 fs1 mf3", o_row_cnt, o_col_cnt, o_frame_start, o_mframe_cnt); end
  endtask

  task automatic test_async_reset();
    skip(1740);
    n_cmp++; if ({o_client_ready, o_row_cnt, o_col_cnt} !== {1'b1, 2'd1, 11'd699}) begin n_bad++; $display("FAIL areset_pre got r%b %0d,%0d want r1 1,699", o_client_ready, o_row_cnt, o_col_cnt); end
    #2 i_rst = 1'b1;
    #1;
    n_cmp++; if (all_out !== 49'd0) begin n_bad++; $display("FAIL areset_immediate got %h want 0", all_out); end
    @(posedge i_clk); #1;
    n_cmp++; if (all_out !== 49'd0) begin n_bad++; $display("FAIL areset_hold got %h want 0", all_out); end
    i_rst = 1'b0;
    step();
    n_cmp++; if (all_out !== 49'd0) begin n_bad++; $display("FAIL areset_idle got %h want 0", all_out); end
    step();
    n_cmp++; if ({o_row_cnt, o_col_cnt, o_frame_start, o_mframe_cnt, o_underrun_cnt} !== {2'd0, 11'd0, 1'b1, 8'd0, 16'd0}) begin n_bad++; $display("FAIL areset_restart got %0d,%0d fs%b mf%0d uc%0d want 0,0 fs1 mf0 uc0", o_row_cnt, o_col_cnt, o_frame_start, o_mframe_cnt, o_underrun_cnt); end
  endtask

  task automatic test_saturation();
    int guard;
    guard = 0;
    i_client_valid = 1'b0; exp_und = 0;
    while (exp_und < 65534 && guard < 70000) begin step(); guard++; end
    n_cmp++; if (guard >= 70000) begin n_bad++; $display("FAIL sat_budget got %0d underruns want 65534", exp_und); end
    n_cmp++; if (o_underrun_cnt !== 16'd65534) begin n_bad++; $display("FAIL sat_below got %0d want 65534", o_underrun_cnt); end
    while (exp_und < 65540 && guard < 70100) begin step(); guard++; end
    n_cmp++; if ({o_underrun_cnt, o_underrun} !== {16'hFFFF, 1'b1}) begin n_bad++; $display("FAIL sat_hold got %h ur%b want ffff ur1", o_underrun_cnt, o_underrun); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_underrun();
    test_overhead();
    test_drain();
    test_reenable();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
